sdram_arbit: RTL

- Central arbiter/sequencer for the single SDRAM command/data port.
- Shares the port between init, auto-refresh, write and read engines.
- Holds the port on init until `flag_init_end`, then grants one engine at a time.
- Drives the muxed command/address/bank/DQ-output bus, and bounds each grant with a watchdog.

---
 rtl/sdram_arbit_pkg.sv | 39 +++
 rtl/sdram_arb_wdog.sv | 55 +++++
 rtl/sdram_arbit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbit_pkg.sv
// ============================================================================
// Module      : sdram_arbit_pkg
// Description : Shared state encodings, SDRAM command codes and default widths
//               for the SDRAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdram_arbit_pkg;

    localparam int DEF_ADDR_W      = 12;
    localparam int DEF_BANK_W      = 2;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_ARBIT = 5'b00010,
        ST_AREF  = 5'b00100,
        ST_WRITE = 5'b01000,
        ST_READ  = 5'b10000
    } arb_state_e;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_MRS       = 4'b0000;
    localparam logic [3:0] CMD_AREF      = 4'b0001;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_NOP       = 4'b0111;

    function automatic logic is_service(input arb_state_e s);
        return (s == ST_AREF) || (s == ST_WRITE) || (s == ST_READ);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_arb_wdog.sv
// ============================================================================
// Module      : sdram_arb_wdog
// Description : Grant watchdog. Counter clears while idle, counts while
//               enabled, and flags expiry on its last count. TIMEOUT_CYC=0
//               removes the counter entirely.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_arb_wdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_wdog_off
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst_n, i_clr, i_en};
            assign o_expire = 1'b0;
        end else begin : g_wdog_on
            localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
            localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYC - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (i_clr) begin
                    cnt_d = '0;
                end else if (i_en) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign o_expire = i_en && (cnt_q == C_LAST);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/sdram_arbit.sv
// ============================================================================
// Module      : sdram_arbit
// Description : Arbiter/sequencer sharing one SDRAM command/data port between
//               init, auto-refresh, write and read engines, with a grant
//               watchdog. Optional macro SDRAM_ARB_RR_EN enables round-robin
//               between simultaneous write and read requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_arbit
    import sdram_arbit_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int BANK_W      = DEF_BANK_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flag_init_end,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              ref_req,
    input  logic              ref_end,
    input  logic [3:0]        ref_cmd,
    input  logic [ADDR_W-1:0] ref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BANK_W-1:0] rd_bank,
    output logic              ref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic [3:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BANK_W-1:0] sdram_bank,
    output logic [DATA_W-1:0] sdram_dq_out,
    output logic              sdram_dq_oe,
    output logic [4:0]        arb_state,
    output logic              timeout_err
);

    arb_state_e state_q, state_d;
    logic       ref_en_q, ref_en_d;
    logic       wr_en_q, wr_en_d;
    logic       rd_en_q, rd_en_d;
    logic       timeout_err_q, timeout_err_d;

    logic       w_svc;
    logic       w_expire;
    logic       w_pick_ref, w_pick_wr, w_pick_rd;

`ifdef SDRAM_ARB_RR_EN
    arb_state_e last_served_q, last_served_d;
`endif

    assign w_svc = is_service(state_q);

    sdram_arb_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (!w_svc),
        .i_en     (w_svc),
        .o_expire (w_expire)
    );

    // Refresh always beats write/read; write/read never chosen with ref_req up.
    always_comb begin
        w_pick_ref = ref_req;
        w_pick_wr  = 1'b0;
        w_pick_rd  = 1'b0;
        if (!ref_req) begin
`ifdef SDRAM_ARB_RR_EN
            if (wr_req && rd_req) begin
                w_pick_wr = (last_served_q != ST_WRITE);
                w_pick_rd = !w_pick_wr;
            end else begin
                w_pick_wr = wr_req;
                w_pick_rd = rd_req;
            end
`else
            w_pick_wr = wr_req;
            w_pick_rd = !wr_req && rd_req;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        ref_en_d      = 1'b0;
        wr_en_d       = 1'b0;
        rd_en_d       = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flag_init_end) begin
                    state_d = ST_ARBIT;
                end
            end
            ST_ARBIT: begin
                // A pending grant pulse commits the transfer into service.
                if (ref_en_q) begin
                    state_d = ST_AREF;
                end else if (wr_en_q) begin
                    state_d = ST_WRITE;
                end else if (rd_en_q) begin
                    state_d = ST_READ;
                end else begin
                    ref_en_d = w_pick_ref;
                    wr_en_d  = w_pick_wr;
                    rd_en_d  = w_pick_rd;
                end
            end
            ST_AREF: begin
                if (ref_end) begin
                    state_d = ST_ARBIT;
                end else if (w_expire) begin
                    state_d       = ST_ARBIT;
                    timeout_err_d = 1'b1;
                end
            end
            ST_WRITE: begin
                if (wr_end) begin
                    state_d = ST_ARBIT;
                end else if (w_expire) begin
                    state_d       = ST_ARBIT;
                    timeout_err_d = 1'b1;
                end
            end
            ST_READ: begin
                if (rd_end) begin
                    state_d = ST_ARBIT;
                end else if (w_expire) begin
                    state_d       = ST_ARBIT;
                    timeout_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef SDRAM_ARB_RR_EN
    always_comb begin
        last_served_d = last_served_q;
        if (state_q == ST_ARBIT) begin
            if (wr_en_q) begin
                last_served_d = ST_WRITE;
            end else if (rd_en_q && !ref_en_q) begin
                last_served_d = ST_READ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_served_q <= ST_READ;
        end else begin
            last_served_q <= last_served_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ref_en_q      <= 1'b0;
            wr_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ref_en_q      <= ref_en_d;
            wr_en_q       <= wr_en_d;
            rd_en_q       <= rd_en_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        sdram_cmd    = CMD_NOP;
        sdram_addr   = '0;
        sdram_bank   = '0;
        sdram_dq_out = '0;
        sdram_dq_oe  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = ref_cmd;
                sdram_addr = ref_addr;
            end
            ST_WRITE: begin
                sdram_cmd    = wr_cmd;
                sdram_addr   = wr_addr;
                sdram_bank   = wr_bank;
                sdram_dq_out = wr_data;
                sdram_dq_oe  = 1'b1;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_bank = rd_bank;
            end
            default: begin
                sdram_cmd = CMD_NOP;
            end
        endcase
    end

    assign ref_en      = ref_en_q;
    assign wr_en       = wr_en_q;
    assign rd_en       = rd_en_q;
    assign timeout_err = timeout_err_q;
    assign arb_state   = state_q;

endmodule

`default_nettype wire
